alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage.sv | 167 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes the ALU operation, holds it in the ID/EX register
// and forwards EX/MEM and MEM/WB results into the operands.
module alu_issue_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [1:0]      id_alu_op,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7_5,
  input  logic [XLEN-1:0] id_rd1,
  input  logic [XLEN-1:0] id_rd2,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_alu_src,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            stall,
  input  logic            flush,
  input  logic            exm_wr,
  input  logic [4:0]      exm_rd,
  input  logic [XLEN-1:0] exm_res,
  input  logic            wb_wr,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_res,
  output logic            ex_valid,
  output logic [3:0]      ex_sel,
  output logic [XLEN-1:0] ex_opa,
  output logic [XLEN-1:0] ex_opb,
  output logic [4:0]      ex_rd,
  output logic            ex_illegal
);

  localparam int unsigned SELW = 4;
  localparam int unsigned REGW = 5;

  localparam logic [SELW-1:0] SEL_AND = 4'b0000;
  localparam logic [SELW-1:0] SEL_OR  = 4'b0001;
  localparam logic [SELW-1:0] SEL_ADD = 4'b0010;
  localparam logic [SELW-1:0] SEL_SUB = 4'b0110;

  logic            valid_q,   valid_d;
  logic [SELW-1:0] sel_q,     sel_d;
  logic [XLEN-1:0] rd1_q,     rd1_d;
  logic [XLEN-1:0] rd2_q,     rd2_d;
  logic [XLEN-1:0] imm_q,     imm_d;
  logic            alu_src_q, alu_src_d;
  logic [REGW-1:0] rs1_q,     rs1_d;
  logic [REGW-1:0] rs2_q,     rs2_d;
  logic [REGW-1:0] rd_q,      rd_d;
  logic            illegal_q, illegal_d;

  logic [SELW-1:0] dec_sel;
  logic            dec_illegal;
  logic [XLEN-1:0] fwd_b;

  // Decode ALU class and function fields into a select code and illegal flag
  always_comb begin
    dec_sel     = SEL_ADD;
    dec_illegal = 1'b0;
    case (id_alu_op)
      2'b00: dec_sel = SEL_ADD;
      2'b01: dec_sel = SEL_SUB;
      default: begin
        case (id_funct3)
          3'b000:  dec_sel = (id_alu_op == 2'b10 && id_funct7_5) ? SEL_SUB : SEL_ADD;
          3'b110:  dec_sel = SEL_OR;
          3'b111:  dec_sel = SEL_AND;
          default: begin
            dec_sel     = SEL_ADD;
            dec_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  // Next stage contents: flush beats stall, invalid or flushed slots become bubbles
  always_comb begin
    valid_d   = valid_q;
    sel_d     = sel_q;
    rd1_d     = rd1_q;
    rd2_d     = rd2_q;
    imm_d     = imm_q;
    alu_src_d = alu_src_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    illegal_d = illegal_q;
    if (flush || !stall) begin
      if (flush || !id_valid) begin
        valid_d   = 1'b0;
        sel_d     = SEL_ADD;
        rd1_d     = '0;
        rd2_d     = '0;
        imm_d     = '0;
        alu_src_d = 1'b0;
        rs1_d     = '0;
        rs2_d     = '0;
        rd_d      = '0;
        illegal_d = 1'b0;
      end else begin
        valid_d   = 1'b1;
        sel_d     = dec_sel;
        rd1_d     = id_rd1;
        rd2_d     = id_rd2;
        imm_d     = id_imm;
        alu_src_d = id_alu_src;
        rs1_d     = id_rs1;
        rs2_d     = id_rs2;
        rd_d      = id_rd;
        illegal_d = dec_illegal;
      end
    end
  end

  // Stage register; reset loads the bubble immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      sel_q     <= SEL_ADD;
      rd1_q     <= '0;
      rd2_q     <= '0;
      imm_q     <= '0;
      alu_src_q <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      sel_q     <= sel_d;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
      imm_q     <= imm_d;
      alu_src_q <= alu_src_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      illegal_q <= illegal_d;
    end
  end

  // Operand forwarding from the held sources, EX/MEM first, x0 never forwarded
  always_comb begin
    ex_opa = rd1_q;
    if (exm_wr && exm_rd == rs1_q && rs1_q != '0) begin
      ex_opa = exm_res;
    end else if (wb_wr && wb_rd == rs1_q && rs1_q != '0) begin
      ex_opa = wb_res;
    end
    fwd_b = rd2_q;
    if (exm_wr && exm_rd == rs2_q && rs2_q != '0) begin
      fwd_b = exm_res;
    end else if (wb_wr && wb_rd == rs2_q && rs2_q != '0) begin
      fwd_b = wb_res;
    end
    ex_opb = alu_src_q ? imm_q : fwd_b;
  end

  assign ex_valid   = valid_q;
  assign ex_sel     = sel_q;
  assign ex_rd      = rd_q;
  assign ex_illegal = illegal_q & valid_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode, bubbles, stall/flush, forwarding, reset.
module tb_alu_issue_stage;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            id_valid;
  logic [1:0]      id_alu_op;
  logic [2:0]      id_funct3;
  logic            id_funct7_5;
  logic [XLEN-1:0] id_rd1, id_rd2, id_imm;
  logic            id_alu_src;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic            stall, flush;
  logic            exm_wr, wb_wr;
  logic [4:0]      exm_rd, wb_rd;
  logic [XLEN-1:0] exm_res, wb_res;
  logic            ex_valid;
  logic [3:0]      ex_sel;
  logic [XLEN-1:0] ex_opa, ex_opb;
  logic [4:0]      ex_rd;
  logic            ex_illegal;

  int tests = 0;
  int fails = 0;

  alu_issue_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_alu_op(id_alu_op), .id_funct3(id_funct3),
    .id_funct7_5(id_funct7_5), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .stall(stall), .flush(flush),
    .exm_wr(exm_wr), .wb_wr(wb_wr), .exm_rd(exm_rd), .wb_rd(wb_rd),
    .exm_res(exm_res), .wb_res(wb_res),
    .ex_valid(ex_valid), .ex_sel(ex_sel), .ex_opa(ex_opa), .ex_opb(ex_opb),
    .ex_rd(ex_rd), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample point: 1 ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] f3,
                       input logic f7, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] imm, input logic src, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [4:0] d);
    id_valid = v; id_alu_op = op; id_funct3 = f3; id_funct7_5 = f7;
    id_rd1 = r1; id_rd2 = r2; id_imm = imm; id_alu_src = src;
    id_rs1 = s1; id_rs2 = s2; id_rd = d;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] sel,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input logic ill);
    chk({tag, ".valid"},   32'(ex_valid),   32'(v));
    chk({tag, ".sel"},     32'(ex_sel),     32'(sel));
    chk({tag, ".opa"},     ex_opa,          a);
    chk({tag, ".opb"},     ex_opb,          b);
    chk({tag, ".rd"},      32'(ex_rd),      32'(d));
    chk({tag, ".illegal"}, 32'(ex_illegal), 32'(ill));
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    exm_wr = 1'b0; wb_wr = 1'b0; exm_rd = '0; wb_rd = '0; exm_res = '0; wb_res = '0;
    // id_* active during reset must have no effect
    drive(1'b1, 2'b10, 3'b000, 1'b1, 32'd10, 32'd3, 32'd0, 1'b0, 5'd1, 5'd2, 5'd7);
    step(); step();
    chk_out("reset", 1'b0, 4'b0010, 32'd0, 32'd0, 5'd0, 1'b0);
    reset = 1'b0;

    // R-type SUB
    step();
    chk_out("r_sub", 1'b1, 4'b0110, 32'd10, 32'd3, 5'd7, 1'b0);
    // R-type ADD, OR, AND
    drive(1'b1, 2'b10, 3'b000, 1'b0, 32'd4, 32'd5, 32'd0, 1'b0, 5'd1, 5'd2, 5'd8);
    step(); chk("r_add.sel", 32'(ex_sel), 32'h2); chk("r_add.opb", ex_opb, 32'd5);
    drive(1'b1, 2'b10, 3'b110, 1'b0, 32'd4, 32'd5, 32'd0, 1'b0, 5'd1, 5'd2, 5'd8);
    step(); chk("r_or.sel", 32'(ex_sel), 32'h1);
    drive(1'b1, 2'b10, 3'b111, 1'b1, 32'd4, 32'd5, 32'd0, 1'b0, 5'd1, 5'd2, 5'd8);
    step(); chk("r_and.sel", 32'(ex_sel), 32'h0);
    drive(1'b1, 2'b10, 3'b001, 1'b0, 32'd4, 32'd5, 32'd0, 1'b0, 5'd1, 5'd2, 5'd8);
    step(); chk("r_bad.sel", 32'(ex_sel), 32'h2); chk("r_bad.ill", 32'(ex_illegal), 32'h1);

    // I-type OR with immediate, funct7_5 set
    drive(1'b1, 2'b11, 3'b110, 1'b1, 32'd1, 32'h55, 32'h0F, 1'b1, 5'd1, 5'd2, 5'd9);
    step();
    chk_out("i_or", 1'b1, 4'b0001, 32'd1, 32'h0F, 5'd9, 1'b0);
    drive(1'b1, 2'b11, 3'b100, 1'b1, 32'd1, 32'h55, 32'h0F, 1'b1, 5'd1, 5'd2, 5'd9);
    step();
    chk("i_bad.sel", 32'(ex_sel), 32'h2); chk("i_bad.ill", 32'(ex_illegal), 32'h1);
    drive(1'b1, 2'b11, 3'b000, 1'b1, 32'd1, 32'h55, 32'h0F, 1'b1, 5'd1, 5'd2, 5'd9);
    step();
    chk("i_add.sel", 32'(ex_sel), 32'h2); chk("i_add.ill", 32'(ex_illegal), 32'h0);

    // Branch and load/store ignore funct fields
    drive(1'b1, 2'b01, 3'b100, 1'b0, 32'd1, 32'd2, 32'd0, 1'b0, 5'd1, 5'd2, 5'd0);
    step(); chk("br.sel", 32'(ex_sel), 32'h6); chk("br.ill", 32'(ex_illegal), 32'h0);
    drive(1'b1, 2'b00, 3'b111, 1'b1, 32'd1, 32'd2, 32'h20, 1'b1, 5'd1, 5'd2, 5'd3);
    step(); chk("ls.sel", 32'(ex_sel), 32'h2); chk("ls.opb", ex_opb, 32'h20);

    // id_valid=0 loads a bubble even with illegal funct3
    drive(1'b0, 2'b10, 3'b011, 1'b1, 32'hDEAD, 32'hBEEF, 32'h7, 1'b1, 5'd4, 5'd5, 5'd6);
    step();
    chk_out("bubble", 1'b0, 4'b0010, 32'd0, 32'd0, 5'd0, 1'b0);

    // Forwarding priority on rs1/rs2
    drive(1'b1, 2'b10, 3'b000, 1'b0, 32'h11, 32'h22, 32'h0, 1'b0, 5'd5, 5'd6, 5'd10);
    step();
    exm_wr = 1'b1; exm_rd = 5'd5; exm_res = 32'hAA;
    wb_wr = 1'b1; wb_rd = 5'd5; wb_res = 32'hBB;
    #1 chk("fwd_exm", ex_opa, 32'hAA); chk("fwd_b_none", ex_opb, 32'h22);
    exm_wr = 1'b0;
    #1 chk("fwd_wb", ex_opa, 32'hBB);
    wb_wr = 1'b0;
    #1 chk("fwd_none", ex_opa, 32'h11);
    wb_wr = 1'b1; wb_rd = 5'd6;
    #1 chk("fwd_b_wb", ex_opb, 32'hBB);
    exm_wr = 1'b1; exm_rd = 5'd6;
    #1 chk("fwd_b_exm", ex_opb, 32'hAA);
    // x0 never forwarded
    drive(1'b1, 2'b10, 3'b000, 1'b0, 32'h33, 32'h44, 32'h0, 1'b0, 5'd0, 5'd0, 5'd1);
    exm_rd = 5'd0; wb_rd = 5'd0;
    step();
    chk("fwd_x0.a", ex_opa, 32'h33); chk("fwd_x0.b", ex_opb, 32'h44);
    exm_wr = 1'b0; wb_wr = 1'b0;

    // Stall holds for 3 cycles with changing id_*
    drive(1'b1, 2'b10, 3'b000, 1'b0, 32'h44, 32'h1, 32'h0, 1'b0, 5'd3, 5'd4, 5'd9);
    step();
    stall = 1'b1;
    drive(1'b0, 2'b10, 3'b110, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    step(); chk_out("stall1", 1'b1, 4'b0010, 32'h44, 32'h1, 5'd9, 1'b0);
    drive(1'b1, 2'b01, 3'b000, 1'b1, 32'h9, 32'h9, 32'h9, 1'b1, 5'd7, 5'd7, 5'd7);
    step(); chk_out("stall2", 1'b1, 4'b0010, 32'h44, 32'h1, 5'd9, 1'b0);
    drive(1'b1, 2'b11, 3'b010, 1'b0, 32'h8, 32'h8, 32'h8, 1'b0, 5'd8, 5'd8, 5'd8);
    step(); chk_out("stall3", 1'b1, 4'b0010, 32'h44, 32'h1, 5'd9, 1'b0);
    // Forwarding still tracks during stall
    exm_wr = 1'b1; exm_rd = 5'd3; exm_res = 32'h99;
    #1 chk("stall_fwd", ex_opa, 32'h99);
    exm_wr = 1'b0;
    // Flush overrides stall
    flush = 1'b1;
    step();
    chk("flush.valid", 32'(ex_valid), 32'h0); chk("flush.sel", 32'(ex_sel), 32'h2);
    chk("flush.rd", 32'(ex_rd), 32'h0);
    flush = 1'b0; stall = 1'b0;

    // Flush alone with a valid instruction
    drive(1'b1, 2'b01, 3'b000, 1'b0, 32'h5, 32'h6, 32'h0, 1'b0, 5'd1, 5'd2, 5'd11);
    flush = 1'b1;
    step(); chk("flush_v.valid", 32'(ex_valid), 32'h0);
    flush = 1'b0;

    // Reset asserted mid-stall, between edges
    drive(1'b1, 2'b01, 3'b000, 1'b0, 32'h5, 32'h6, 32'h0, 1'b0, 5'd1, 5'd2, 5'd12);
    step();
    chk("pre_rst.valid", 32'(ex_valid), 32'h1);
    stall = 1'b1;
    #2 reset = 1'b1;
    #1 chk_out("async_rst", 1'b0, 4'b0010, 32'd0, 32'd0, 5'd0, 1'b0);
    #1 reset = 1'b0; stall = 1'b0;
    drive(1'b1, 2'b10, 3'b000, 1'b1, 32'h30, 32'h10, 32'h0, 1'b0, 5'd1, 5'd2, 5'd13);
    step();
    chk_out("post_rst", 1'b1, 4'b0110, 32'h30, 32'h10, 5'd13, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
